sram_uart_bus_ctrl: RTL and testbench

SRAM_UART_BUS_CTRL -- requirements
Module: sram_uart_bus_ctrl

---
 rtl/sram_uart_bus_ctrl_if.sv | 27 ++
 rtl/sram_uart_bus_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sram_uart_bus_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_uart_bus_ctrl_if.sv
// Client-side request/response bundle for sram_uart_bus_ctrl.
// The master issues req with its command fields; the slave returns the ack pulse, rdata and busy.
interface sram_uart_bus_ctrl_if #(
    parameter int ADDR_W = 20
);
    logic              req;
    logic              wr;
    logic              uart_sel;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_off;
    logic [1:0]        size;
    logic              sext;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              busy;

    modport master (
        output req, wr, uart_sel, addr, byte_off, size, sext, wdata,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, wr, uart_sel, addr, byte_off, size, sext, wdata,
        output ack, rdata, busy
    );
endinterface

// File: rtl/sram_uart_bus_ctrl.sv
// Single-access SRAM/UART bus sequencer with lane masking and load extension; SRAM read ack at T+WAIT_CYC+2, write ack at T+WAIT_CYC+3.
// No queueing: req is only taken in IDLE. Define UART_TSRE_WAIT_EN to hold UART write ack until the shifter empties.
module sram_uart_bus_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int WAIT_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_uart_bus_ctrl_if.slave  cli,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [3:0]           sram_be_n,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [31:0]          bus_o,
    output logic                 bus_oe,
    input  logic [31:0]          bus_i,
    output logic                 uart_rdn,
    output logic                 uart_wrn,
    input  logic                 uart_dataready,
    input  logic                 uart_tbre,
    input  logic                 uart_tsre
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SR_RD   = 4'd1;
    localparam logic [3:0] SR_WS   = 4'd2;
    localparam logic [3:0] SR_WL   = 4'd3;
    localparam logic [3:0] SR_WH   = 4'd4;
    localparam logic [3:0] U_RWAIT = 4'd5;
    localparam logic [3:0] U_RD    = 4'd6;
    localparam logic [3:0] U_WL    = 4'd7;
    localparam logic [3:0] U_TBRE  = 4'd8;
    localparam logic [3:0] U_TSRE  = 4'd9;
    localparam logic [3:0] DONE    = 4'd10;

    localparam logic [3:0] WAIT_LAST = WAIT_CYC[3:0];

    logic [3:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [3:0]        be_q;
    logic [31:0]       wdat_q;
    logic [31:0]       rdata_q;

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // Selected field is shifted down first, then zero- or sign-extended from its top bit.
    function automatic logic [31:0] load_data(input logic [31:0] d, input logic [1:0] sz,
                                              input logic [1:0] off, input logic sx);
        logic [31:0] bsh;
        logic [31:0] hsh;
        bsh = d >> {off, 3'b000};
        hsh = d >> {off[1], 4'b0000};
        case (sz)
            2'b00:   load_data = {{24{sx & bsh[7]}}, bsh[7:0]};
            2'b01:   load_data = {{16{sx & hsh[15]}}, hsh[15:0]};
            default: load_data = d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            be_q    <= 4'hF;
            wdat_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cli.req) begin
                        addr_q <= cli.addr;
                        off_q  <= cli.byte_off;
                        size_q <= cli.size;
                        sext_q <= cli.sext;
                        be_q   <= ~lane_mask(cli.size, cli.byte_off);
                        cnt    <= '0;
                        wdat_q <= cli.uart_sel ? {24'b0, cli.wdata[7:0]}
                                               : store_data(cli.size, cli.wdata);
                        if (!cli.uart_sel) begin
                            state <= cli.wr ? SR_WS : SR_RD;
                        end else if (cli.wr) begin
                            state <= U_WL;
                        end else if (cli.addr[0]) begin
                            rdata_q <= {30'b0, uart_tsre & uart_tbre, uart_dataready};
                            state   <= DONE;
                        end else begin
                            state <= U_RWAIT;
                        end
                    end
                end
                SR_RD: begin
                    if (cnt == WAIT_LAST) begin
                        rdata_q <= load_data(bus_i, size_q, off_q, sext_q);
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SR_WS: begin
                    cnt   <= '0;
                    state <= SR_WL;
                end
                SR_WL: begin
                    if (cnt == WAIT_LAST) state <= SR_WH;
                    else                  cnt   <= cnt + 4'd1;
                end
                SR_WH: state <= IDLE;
                U_RWAIT: begin
                    if (uart_dataready) begin
                        cnt   <= '0;
                        state <= U_RD;
                    end
                end
                U_RD: begin
                    if (cnt == WAIT_LAST) begin
                        rdata_q <= load_data({24'b0, bus_i[7:0]}, 2'b00, 2'b00, sext_q);
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                U_WL: begin
                    if (cnt == WAIT_LAST) state <= U_TBRE;
                    else                  cnt   <= cnt + 4'd1;
                end
                U_TBRE: begin
`ifdef UART_TSRE_WAIT_EN
                    if (uart_tbre) state <= U_TSRE;
`else
                    if (uart_tbre) state <= DONE;
`endif
                end
                U_TSRE: begin
`ifdef UART_TSRE_WAIT_EN
                    if (uart_tsre) state <= DONE;
`else
                    state <= DONE;
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The write hold cycle doubles as the write completion cycle, keeping data driven while ack is seen.
    always_comb begin
        sram_ce_n = !(state inside {SR_RD, SR_WS, SR_WL, SR_WH});
        sram_oe_n = (state != SR_RD);
        sram_we_n = (state != SR_WL);
        sram_be_n = sram_ce_n ? 4'hF : be_q;
        sram_addr = addr_q;
        bus_oe    = state inside {SR_WS, SR_WL, SR_WH, U_WL, U_TBRE, U_TSRE};
        bus_o     = bus_oe ? wdat_q : 32'h0;
        uart_rdn  = (state != U_RD);
        uart_wrn  = (state != U_WL);
        cli.ack   = (state == DONE) || (state == SR_WH);
        cli.busy  = (state != IDLE);
        cli.rdata = rdata_q;
    end

endmodule

// File: tb/tb_sram_uart_bus_ctrl.sv
// Directed bench for sram_uart_bus_ctrl with a behavioural byte-lane SRAM and a scripted UART.
module tb_sram_uart_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;
    logic [19:0] sram_addr;
    logic [31:0] bus_o;
    logic        bus_oe;
    logic [31:0] bus_i;
    logic        uart_rdn, uart_wrn;
    logic        uart_dataready, uart_tbre, uart_tsre;
    logic [7:0]  uart_rx;
    logic [31:0] mem [0:255];
    logic [31:0] sram_nw;
    int          checks = 0;
    int          errors = 0;
    int          n;
    int          lo;

    always #5 clk = ~clk;

    sram_uart_bus_ctrl_if #(.ADDR_W(20)) cli ();

    sram_uart_bus_ctrl #(.ADDR_W(20), .WAIT_CYC(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .cli            (cli),
        .sram_ce_n      (sram_ce_n),
        .sram_oe_n      (sram_oe_n),
        .sram_we_n      (sram_we_n),
        .sram_be_n      (sram_be_n),
        .sram_addr      (sram_addr),
        .bus_o          (bus_o),
        .bus_oe         (bus_oe),
        .bus_i          (bus_i),
        .uart_rdn       (uart_rdn),
        .uart_wrn       (uart_wrn),
        .uart_dataready (uart_dataready),
        .uart_tbre      (uart_tbre),
        .uart_tsre      (uart_tsre)
    );

    assign bus_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]]
                 : (!uart_rdn ? {24'hC3C3C3, uart_rx} : 32'hDEADBEEF);

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            sram_nw = mem[sram_addr[7:0]];
            for (int i = 0; i < 4; i++)
                if (!sram_be_n[i]) sram_nw[8*i +: 8] = bus_o[8*i +: 8];
            mem[sram_addr[7:0]] <= sram_nw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pins must never drive the bus while the SRAM has its outputs enabled.
    always @(negedge clk) begin
        if (rst === 1'b0) chk("oe_conflict", 32'(!sram_oe_n && bus_oe), 32'h0);
    end

    task automatic start(input logic w, input logic u, input logic [19:0] a, input logic [1:0] bo,
                         input logic [1:0] sz, input logic sx, input logic [31:0] wd);
        @(negedge clk);
        cli.req = 1'b1; cli.wr = w; cli.uart_sel = u; cli.addr = a;
        cli.byte_off = bo; cli.size = sz; cli.sext = sx; cli.wdata = wd;
        @(negedge clk);
        cli.req = 1'b0;
    endtask

    task automatic wait_ack(input int lim, output int cyc);
        cyc = 0;
        while (cli.ack !== 1'b1 && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic sram_read(input string tag, input logic [19:0] a, input logic [1:0] bo,
                             input logic [1:0] sz, input logic sx, input logic [3:0] exp_be,
                             input logic [31:0] exp_rd);
        int cyc;
        start(1'b0, 1'b0, a, bo, sz, sx, 32'h0);
        chk({tag, "_be"}, 32'(sram_be_n), 32'(exp_be));
        wait_ack(20, cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'd2);
        chk({tag, "_rdata"}, cli.rdata, exp_rd);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 1'b1;
        cli.req = 1'b0; cli.wr = 1'b0; cli.uart_sel = 1'b0; cli.addr = '0;
        cli.byte_off = 2'b00; cli.size = 2'b00; cli.sext = 1'b0; cli.wdata = 32'h0;
        uart_dataready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0; uart_rx = 8'h41;
        repeat (3) @(negedge clk);

        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, bus_oe}), 32'hE);
        chk("rst_be", 32'(sram_be_n), 32'hF);
        chk("rst_uart", 32'({uart_rdn, uart_wrn}), 32'h3);
        chk("rst_ack_busy", 32'({cli.ack, cli.busy}), 32'h0);
        chk("rst_rdata", cli.rdata, 32'h0);
        rst = 1'b0;

        // Word write: setup cycle, two we_n-low cycles, then hold cycle with ack.
        start(1'b1, 1'b0, 20'h00010, 2'b00, 2'b10, 1'b0, 32'h8765_4321);
        chk("wr_setup", 32'({sram_ce_n, sram_we_n, bus_oe, cli.ack}), 32'b0110);
        chk("wr_bus_o", bus_o, 32'h8765_4321);
        @(negedge clk); chk("wr_we_t2", 32'(sram_we_n), 32'h0);
        @(negedge clk); chk("wr_we_t3", 32'(sram_we_n), 32'h0);
        @(negedge clk); chk("wr_end_t4", 32'({sram_we_n, bus_oe, cli.ack, cli.busy}), 32'b1111);
        @(negedge clk); chk("wr_idle", 32'({cli.ack, cli.busy}), 32'h0);

        // Word read with explicit per-cycle strobe checks.
        start(1'b0, 1'b0, 20'h00010, 2'b00, 2'b10, 1'b0, 32'h0);
        chk("rd_t1", 32'({sram_ce_n, sram_oe_n, sram_we_n, bus_oe, cli.ack}), 32'b00100);
        @(negedge clk); chk("rd_t2", 32'({sram_ce_n, sram_oe_n, cli.ack}), 32'b000);
        @(negedge clk); chk("rd_t3", 32'({sram_oe_n, cli.ack}), 32'b11);
        chk("rd_rdata", cli.rdata, 32'h8765_4321);

        sram_read("rd_b3s", 20'h00010, 2'd3, 2'b00, 1'b1, 4'b0111, 32'hFFFF_FF87);
        sram_read("rd_b3u", 20'h00010, 2'd3, 2'b00, 1'b0, 4'b0111, 32'h0000_0087);
        sram_read("rd_h2s", 20'h00010, 2'd2, 2'b01, 1'b1, 4'b0011, 32'hFFFF_8765);
        sram_read("rd_h1s", 20'h00010, 2'd1, 2'b01, 1'b1, 4'b1100, 32'h0000_4321);
        sram_read("rd_b0s", 20'h00010, 2'd0, 2'b00, 1'b1, 4'b1110, 32'h0000_0021);

        // Byte store into lane 1 only.
        start(1'b1, 1'b0, 20'h00010, 2'd1, 2'b00, 1'b0, 32'h0000_00A5);
        chk("bst_be", 32'(sram_be_n), 32'hD);
        chk("bst_bus_o", bus_o, 32'hA5A5_A5A5);
        wait_ack(20, n);
        chk("bst_lat", 32'(n), 32'd3);
        chk("bst_rdata_kept", cli.rdata, 32'h0000_0021);
        sram_read("rd_after_bst", 20'h00010, 2'd0, 2'b10, 1'b0, 4'b0000, 32'h8765_A521);

        // A second req while busy is dropped.
        start(1'b0, 1'b0, 20'h00010, 2'd0, 2'b10, 1'b0, 32'h0);
        cli.req = 1'b1; cli.wr = 1'b1;
        @(negedge clk); cli.req = 1'b0;
        wait_ack(20, n);
        @(negedge clk); chk("busy_req_dropped", 32'(cli.busy), 32'h0);
        @(negedge clk); chk("busy_req_dropped2", 32'(cli.busy), 32'h0);

        // UART data read waits for dataready.
        start(1'b0, 1'b1, 20'h00000, 2'd0, 2'b00, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("urd_wait", 32'({uart_rdn, cli.busy, cli.ack}), 32'b110);
            @(negedge clk);
        end
        uart_dataready = 1'b1;
        lo = 0; n = 0;
        while (cli.ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (!uart_rdn) lo++;
        end
        chk("urd_rdn_cycles", 32'(lo), 32'd2);
        chk("urd_rdata", cli.rdata, 32'h0000_0041);
        uart_dataready = 1'b0;

        // Status reads: immediate ack, no strobe.
        uart_dataready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
        start(1'b0, 1'b1, 20'h00001, 2'd0, 2'b00, 1'b0, 32'h0);
        chk("ust_ack", 32'({cli.ack, uart_rdn}), 32'b11);
        chk("ust_rdata_a", cli.rdata, 32'h3);
        uart_tsre = 1'b0;
        start(1'b0, 1'b1, 20'h00001, 2'd0, 2'b00, 1'b0, 32'h0);
        chk("ust_rdata_b", cli.rdata, 32'h1);
        uart_dataready = 1'b0; uart_tbre = 1'b0;

        // UART write: strobe, then wait for transmitter flags.
        start(1'b1, 1'b1, 20'h00000, 2'd0, 2'b00, 1'b0, 32'h1234_565A);
        chk("uwr_t1", 32'({uart_wrn, bus_oe}), 32'b01);
        chk("uwr_bus_o", bus_o, 32'h0000_005A);
        @(negedge clk); chk("uwr_t2", 32'(uart_wrn), 32'h0);
        @(negedge clk); chk("uwr_t3", 32'({uart_wrn, cli.ack, cli.busy}), 32'b101);
        @(negedge clk); chk("uwr_t4", 32'(cli.ack), 32'h0);
        uart_tbre = 1'b1;
        @(negedge clk);
`ifdef UART_TSRE_WAIT_EN
        for (int i = 0; i < 4; i++) begin
            chk("uwr_tsre_wait", 32'({cli.ack, cli.busy}), 32'b01);
            if (i < 3) @(negedge clk);
        end
        uart_tsre = 1'b1;
        @(negedge clk);
`endif
        chk("uwr_ack", 32'(cli.ack), 32'h1);
        @(negedge clk); chk("uwr_idle", 32'(cli.busy), 32'h0);
        uart_tbre = 1'b0; uart_tsre = 1'b0;

        // Reset mid-write aborts without ack.
        start(1'b1, 1'b0, 20'h00020, 2'd0, 2'b10, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk); chk("rwl_we", 32'(sram_we_n), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rwl_abort", 32'({sram_we_n, sram_ce_n, bus_oe, cli.ack, cli.busy}), 32'b11000);
        chk("rwl_rdata", cli.rdata, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("rwl_no_ack", 32'(cli.ack), 32'h0);
        end
        sram_read("rd_after_rst", 20'h00010, 2'd0, 2'b10, 1'b0, 4'b0000, 32'h8765_A521);

        // Reset beats a simultaneous req.
        @(negedge clk);
        rst = 1'b1; cli.req = 1'b1; cli.wr = 1'b0; cli.uart_sel = 1'b0;
        @(negedge clk);
        chk("rst_prio", 32'({cli.busy, sram_ce_n}), 32'b01);
        rst = 1'b0; cli.req = 1'b0;
        @(negedge clk); chk("rst_prio_idle", 32'(cli.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
